// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core.
// Sequences memory, ALU, register file and PC.
//
// Ports:
//   clk, rst      clock, sync active-high reset
//   op            instr[6:0] from the IR
//   funct3        instr[14:12]
//   funct7b5      instr[30]
//   EQ            ALU equality flag
//   mem_ready     memory finishes access now
//   mem_req       memory request, held to ready
//   MemWrite      request is a store
//   AdrSrc        0: PC, 1: ALUOut address
//   IRWrite       load IR and OldPC
//   PCWrite       PC <= PC-next result
//   RegWrite      register file write enable
//   ALUSrcA       00 PC, 01 OldPC, 10 RD1
//   ALUSrcB       00 RD2, 01 Imm, 10 const 4
//   ResultSrc     00 ALUOut, 01 MDR, 10 ALU
//   ImmSrc        00 I, 01 S, 10 B, 11 J
//   ALUctrl       000 add 001 sub 010 and
//                 011 or 101 slt
//   halted        sticky illegal-instr flag
//   instret       retired instruction count
module multicycle_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 EQ,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUctrl,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] A_ADD = 3'b000;
  localparam logic [2:0] A_SUB = 3'b001;
  localparam logic [2:0] A_AND = 3'b010;
  localparam logic [2:0] A_OR  = 3'b011;
  localparam logic [2:0] A_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_HALT
  } state_t;

  state_t               state_q, state_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 retire;

  logic                 f3_alu_ok;
  logic                 f3_br_ok;
  logic                 taken;
  logic [2:0]           alu_r;
  logic [2:0]           alu_i;

  // ALU op shared by R and I forms; only
  // the R form may turn add into sub.
  function automatic logic [2:0] alu_of(
    input logic [2:0] f3,
    input logic       sub
  );
    logic [2:0] r;
    r = A_ADD;
    case (f3)
      3'b000:  r = sub ? A_SUB : A_ADD;
      3'b111:  r = A_AND;
      3'b110:  r = A_OR;
      3'b010:  r = A_SLT;
      default: r = A_ADD;
    endcase
    return r;
  endfunction

  always_comb begin
    f3_alu_ok = (funct3 == 3'b000) ||
                (funct3 == 3'b111) ||
                (funct3 == 3'b110) ||
                (funct3 == 3'b010);
    f3_br_ok  = (funct3 == 3'b000) ||
                (funct3 == 3'b001);
    taken     = ((funct3 == 3'b000) && EQ) ||
                ((funct3 == 3'b001) && !EQ);
    alu_r     = alu_of(funct3, funct7b5);
    alu_i     = alu_of(funct3, 1'b0);
  end

  // Next state and retirement
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE:
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_HALT;
        endcase
      S_MEMADR:
        state_d = (op == OP_LOAD) ? S_MEMREAD
                                  : S_MEMWRITE;
      S_MEMREAD:
        if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE:
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      S_EXECR, S_EXECI:
        state_d = f3_alu_ok ? S_ALUWB : S_HALT;
      S_ALUWB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH:
        if (f3_br_ok) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      // JAL retires once, in ALUWB
      S_JAL:
        state_d = S_ALUWB;
      S_HALT:
        state_d = S_HALT;
      default:
        state_d = S_HALT;
    endcase
    halted_d  = halted_q || (state_d == S_HALT);
    instret_d = instret_q +
                {{(CNT_WIDTH-1){1'b0}}, retire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      instret_q <= instret_d;
    end
  end

  logic       req_c, mw_c, adr_c;
  logic       irw_c, pcw_c, rgw_c;
  logic [1:0] sa_c, sb_c, rs_c, imm_c;
  logic [2:0] alu_c;

  // Moore decode; only the enables look at
  // the handshake and branch flag.
  always_comb begin
    req_c = 1'b0;
    mw_c  = 1'b0;
    adr_c = 1'b0;
    irw_c = 1'b0;
    pcw_c = 1'b0;
    rgw_c = 1'b0;
    sa_c  = 2'b00;
    sb_c  = 2'b00;
    rs_c  = 2'b00;
    imm_c = 2'b00;
    alu_c = A_ADD;
    unique case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        sb_c  = 2'b10;
        rs_c  = 2'b10;
        irw_c = mem_ready;
        pcw_c = mem_ready;
      end
      S_DECODE: begin
        sa_c  = 2'b01;
        sb_c  = 2'b01;
        // jal needs its J-immediate target here
        imm_c = (op == OP_JAL) ? 2'b11 : 2'b10;
      end
      S_MEMADR: begin
        sa_c  = 2'b10;
        sb_c  = 2'b01;
        imm_c = (op == OP_STORE) ? 2'b01
                                 : 2'b00;
      end
      S_MEMREAD: begin
        req_c = 1'b1;
        adr_c = 1'b1;
      end
      S_MEMWB: begin
        rs_c  = 2'b01;
        rgw_c = 1'b1;
      end
      S_MEMWRITE: begin
        req_c = 1'b1;
        mw_c  = 1'b1;
        adr_c = 1'b1;
        imm_c = 2'b01;
      end
      S_EXECR: begin
        sa_c  = 2'b10;
        alu_c = alu_r;
      end
      S_EXECI: begin
        sa_c  = 2'b10;
        sb_c  = 2'b01;
        alu_c = alu_i;
      end
      S_ALUWB: begin
        rgw_c = 1'b1;
      end
      S_BRANCH: begin
        sa_c  = 2'b10;
        imm_c = 2'b10;
        alu_c = A_SUB;
        pcw_c = taken;
      end
      S_JAL: begin
        sa_c  = 2'b01;
        sb_c  = 2'b10;
        imm_c = 2'b11;
        pcw_c = 1'b1;
      end
      S_HALT: begin
      end
      default: begin
      end
    endcase
  end

  // No architectural write while in reset
  assign mem_req   = req_c;
  assign MemWrite  = mw_c  & ~rst;
  assign IRWrite   = irw_c & ~rst;
  assign PCWrite   = pcw_c & ~rst;
  assign RegWrite  = rgw_c & ~rst;
  assign AdrSrc    = adr_c;
  assign ALUSrcA   = sa_c;
  assign ALUSrcB   = sb_c;
  assign ResultSrc = rs_c;
  assign ImmSrc    = imm_c;
  assign ALUctrl   = alu_c;
  assign halted    = halted_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller.
// Instruction-level model feeds per-cycle expectations.
module tb_multicycle_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic          EQ;
  logic          mem_ready;
  logic          mem_req, MemWrite, AdrSrc;
  logic          IRWrite, PCWrite, RegWrite;
  logic [1:0]    ALUSrcA, ALUSrcB;
  logic [1:0]    ResultSrc, ImmSrc;
  logic [2:0]    ALUctrl;
  logic          halted;
  logic [CW-1:0] instret;

  multicycle_controller #(.CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .EQ        (EQ),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ImmSrc    (ImmSrc),
    .ALUctrl   (ALUctrl),
    .halted    (halted),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;

  // {irw,pcw,rgw,mw,req,halted,adr,
  //  sa,sb,rs,imm,alu}
  typedef struct packed {
    logic [17:0]   v;
    logic [17:0]   m;
    logic [CW-1:0] c;
    logic          cc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   icnt  = 0;
  int   ncyc  = 0;

  logic [2:0] lg [4] = '{3'b000, 3'b111,
                         3'b110, 3'b010};
  logic [6:0] bad [4] = '{7'b0000000,
                          7'b1110011,
                          7'b0110111,
                          7'b0010111};

  function automatic logic [17:0] pk(
    input logic irw, pcw, rgw, mw, req, hl,
    input logic adr,
    input logic [1:0] sa, sb, rs, imm,
    input logic [2:0] alu
  );
    return {irw, pcw, rgw, mw, req, hl, adr,
            sa, sb, rs, imm, alu};
  endfunction

  function automatic logic [17:0] mk(
    input bit adr, sa, sb, rs, imm, alu
  );
    return {6'b111111, adr, {2{sa}}, {2{sb}},
            {2{rs}}, {2{imm}}, {3{alu}}};
  endfunction

  function automatic logic [2:0] alu_ref(
    input logic [2:0] f3,
    input logic f7,
    input bit isr
  );
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b010) return 3'b101;
    return (isr && f7) ? SUB : ADD;
  endfunction

  function automatic bit alu_ok(input logic [2:0] f3);
    return f3 == 3'b000 || f3 == 3'b111 ||
           f3 == 3'b110 || f3 == 3'b010;
  endfunction

  task automatic cyc(
    input logic [17:0] v,
    input logic [17:0] m,
    input bit cc,
    input bit ret
  );
    exp_t e;
    e.v  = v;
    e.m  = m;
    e.c  = icnt[CW-1:0];
    e.cc = cc;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (ret) icnt++;
  endtask

  task automatic fetch(input int w);
    for (int i = 0; i < w; i++) begin
      mem_ready = 1'b0;
      EQ = 1'($urandom);
      cyc(pk(0,0,0,0,1,0,0,2'b00,2'b10,2'b10,
             2'b00,ADD),
          mk(1,1,1,1,0,1), 1, 0);
    end
    mem_ready = 1'b1;
    cyc(pk(1,1,0,0,1,0,0,2'b00,2'b10,2'b10,
           2'b00,ADD),
        mk(1,1,1,1,0,1), 1, 0);
  endtask

  task automatic wb(input logic [1:0] rs);
    mem_ready = 1'($urandom);
    cyc(pk(0,0,1,0,0,0,0,2'b00,2'b00,rs,
           2'b00,ADD),
        mk(0,0,0,1,0,0), 1, 1);
  endtask

  task automatic halt_seq();
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom);
      EQ = 1'($urandom);
      cyc(pk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,
             2'b00,ADD),
          mk(0,0,0,0,0,0), 1, 0);
    end
    rst = 1'b1;
    cyc(pk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,
           2'b00,ADD),
        mk(0,0,0,0,0,0), 1, 0);
    rst  = 1'b0;
    icnt = 0;
  endtask

  task automatic instr(
    input logic [6:0] o,
    input logic [2:0] f3,
    input logic f7,
    input int wf,
    input int wm,
    input logic eqv,
    input bit abort
  );
    bit isr;
    bit tk;
    fetch(wf);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    mem_ready = 1'($urandom);
    EQ = 1'($urandom);
    cyc(pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,
           2'b10,ADD),
        mk(0,1,1,0,o != JL,1), 1, 0);
    case (o)
      RT, IT: begin
        isr = (o == RT);
        mem_ready = 1'($urandom);
        cyc(pk(0,0,0,0,0,0,0,2'b10,
               isr ? 2'b00 : 2'b01,2'b00,2'b00,
               alu_ref(f3, f7, isr)),
            mk(0,1,1,0,0,alu_ok(f3)), 1, 0);
        if (alu_ok(f3)) wb(2'b00);
        else halt_seq();
      end
      LW, SW: begin
        mem_ready = 1'($urandom);
        cyc(pk(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,
               (o == SW) ? 2'b01 : 2'b00,ADD),
            mk(0,1,1,0,1,1), 1, 0);
        if (abort) begin
          rst = 1'b1;
          mem_ready = 1'b1;
          cyc(pk(0,0,0,0,1,0,1,2'b00,2'b00,
                 2'b00,2'b00,ADD),
              mk(1,0,0,0,0,0), 1, 0);
          rst = 1'b0;
          icnt = 0;
        end else begin
          for (int i = 0; i <= wm; i++) begin
            mem_ready = (i == wm);
            cyc(pk(0,0,0,o == SW,1,0,1,2'b00,
                   2'b00,2'b00,2'b00,ADD),
                mk(1,0,0,0,0,0), 1,
                (o == SW) && (i == wm));
          end
          if (o == LW) wb(2'b01);
        end
      end
      BR: begin
        EQ = eqv;
        mem_ready = 1'($urandom);
        tk = (f3 == 3'b000) ? eqv :
             (f3 == 3'b001) ? !eqv : 1'b0;
        cyc(pk(0,tk,0,0,0,0,0,2'b10,2'b00,2'b00,
               2'b00,SUB),
            mk(0,1,1,0,0,1), 1, f3[2:1] == 2'b00);
        if (f3[2:1] != 2'b00) halt_seq();
      end
      JL: begin
        mem_ready = 1'($urandom);
        cyc(pk(0,1,0,0,0,0,0,2'b01,2'b10,2'b00,
               2'b00,ADD),
            mk(0,1,1,0,0,1), 1, 0);
        wb(2'b00);
      end
      default: halt_seq();
    endcase
  endtask

  // Monitor: one expectation per cycle
  initial begin
    exp_t        e;
    logic [17:0] a;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        a = {IRWrite, PCWrite, RegWrite,
             MemWrite, mem_req, halted, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc,
             ImmSrc, ALUctrl};
        tests++;
        if (((a ^ e.v) & e.m) != 18'd0 ||
            (e.cc && instret != e.c)) begin
          fails++;
          $display("FAIL cyc%0d: got %b cnt %0d, required %b cnt %0d (mask %b)",
                   ncyc, a, instret, e.v, e.c, e.m);
        end
        ncyc++;
      end
    end
  end

  initial begin
    logic [6:0] o;
    logic [2:0] f3;
    int         k;
    rst = 1'b1;
    op = 7'd0;
    funct3 = 3'd0;
    funct7b5 = 1'b0;
    EQ = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // reset state: FETCH, req up, no writes
    cyc(pk(0,0,0,0,1,0,0,2'b00,2'b10,2'b10,
           2'b00,ADD),
        mk(1,1,1,1,0,1), 1, 0);
    rst = 1'b0;

    instr(IT, 3'b000, 1'b1, 0, 0, 1'b0, 0);
    instr(RT, 3'b000, 1'b1, 3, 0, 1'b0, 0);
    instr(BR, 3'b000, 1'b0, 0, 0, 1'b1, 0);
    instr(BR, 3'b000, 1'b0, 0, 0, 1'b0, 0);
    instr(BR, 3'b001, 1'b0, 0, 0, 1'b1, 0);
    instr(BR, 3'b001, 1'b0, 0, 0, 1'b0, 0);
    instr(LW, 3'b010, 1'b0, 0, 2, 1'b0, 0);
    instr(SW, 3'b010, 1'b0, 1, 1, 1'b0, 0);
    instr(JL, 3'b000, 1'b0, 0, 0, 1'b0, 0);
    instr(RT, 3'b111, 1'b0, 0, 0, 1'b0, 0);
    instr(RT, 3'b110, 1'b0, 0, 0, 1'b0, 0);
    instr(IT, 3'b010, 1'b0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 20; i++)
      instr(IT, 3'b000, 1'b0, 0, 0, 1'b0, 0);
    instr(7'b0000000, 3'b000, 1'b0, 0, 0,
          1'b0, 0);
    instr(IT, 3'b000, 1'b0, 0, 0, 1'b0, 0);
    instr(SW, 3'b010, 1'b0, 0, 0, 1'b0, 1);
    instr(IT, 3'b000, 1'b0, 0, 0, 1'b0, 0);

    for (int n = 0; n < 300; n++) begin
      k  = $urandom_range(0, 11);
      f3 = lg[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0)
        f3 = 3'($urandom_range(0, 7));
      case (k)
        0, 1:   o = RT;
        2, 3:   o = IT;
        4:      o = LW;
        5:      o = SW;
        6, 7: begin
          o  = BR;
          f3 = 3'($urandom_range(0, 1));
          if ($urandom_range(0, 9) == 0)
            f3 = 3'($urandom_range(2, 7));
        end
        8:      o = JL;
        9:      o = bad[$urandom_range(0, 3)];
        default: o = IT;
      endcase
      instr(o, f3, 1'($urandom),
            $urandom_range(0, 2),
            $urandom_range(0, 2),
            1'($urandom), 0);
    end

    @(posedge clk);
    @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, required 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
